lap_stopwatch_core: RTL and testbench

//  Parametrised stopwatch/timer core replacing the fixed moore_machine + timer + output_sel chain.

---
 rtl/lap_stopwatch_core_pkg.sv | 25 ++
 rtl/lap_stopwatch_core_tick_gen.sv | 28 ++
 rtl/lap_stopwatch_core.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lap_stopwatch_core.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_stopwatch_core_pkg.sv
// Shared types for the lap stopwatch: FSM encodings, the {m,s,cs} lap word and a clamp helper.
package stopwatch_pkg;

  localparam int LAP_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_SPLIT = 3'd3,
    ST_DONE  = 3'd4
  } sw_state_e;

  // Field order is fixed: minutes in the top byte, sub-seconds in the bottom byte.
  typedef struct packed {
    logic [7:0] m;
    logic [7:0] s;
    logic [7:0] cs;
  } lap_t;

  function automatic logic [7:0] clamp8(input logic [7:0] val, input logic [7:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/lap_stopwatch_core_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles; holds when disabled.
module tick_gen #(
  parameter int DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_r;

  assign tick = en && (cnt_r == CW'(DIV - 1));

  // Prescaler count: cleared on reset/clear, wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch/timer core: run/pause/split/done FSM, up/down mm:ss.cc counter and a lap FIFO.
// Display fields are a combinational mux between the live counter and the frozen split value.
module lap_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int MIN_MAX   = 99,
  parameter int LAP_DEPTH = 8,
  parameter int MODE_W    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              btn_ss,
  input  logic              btn_lap,
  input  logic              btn_clr,
  input  logic [MODE_W-1:0] mode,
  input  logic [7:0]        load_m,
  input  logic [7:0]        load_s,
  input  logic              lap_rd,
  output logic [7:0]        disp_cs,
  output logic [7:0]        disp_s,
  output logic [7:0]        disp_m,
  output logic [2:0]        state,
  output logic              done,
  output logic              ovf,
  output logic [LAP_W-1:0]  lap_data,
  output logic              lap_empty,
  output logic              lap_full,
  output logic              lap_lost
);
  localparam int         DIV    = CLK_HZ / TICK_HZ;
  localparam int         PTR_W  = $clog2(LAP_DEPTH);
  localparam int         PW     = PTR_W + 1;
  localparam logic [7:0] CS_MAX = 8'(TICK_HZ - 1);
  localparam logic [7:0] M_MAX  = 8'(MIN_MAX);
  localparam logic [7:0] S_MAX  = 8'd59;

  sw_state_e     state_r, state_nx_s, btn_nx_s;
  lap_t          cnt_r, frz_r, inc_s, dec_s, idle_val_s;
  lap_t          mem_r [LAP_DEPTH];
  logic [PW-1:0] wr_r, rd_r;
  logic          dir_r, ovf_r, done_r, lost_r;
  logic          clr_s, ss_s, lap_s, run_s, tick_s, start_s, push_s, done_nx_s;
  logic          wrap_s, zero_s, load_zero_s, empty_s, full_s, do_push_s, do_pop_s;

  // Clear beats start/stop beats lap when pulses coincide.
  assign clr_s = btn_clr;
  assign ss_s  = btn_ss && !btn_clr;
  assign lap_s = btn_lap && !btn_ss && !btn_clr;
  assign run_s = (state_r == ST_RUN) || (state_r == ST_SPLIT);

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (CLK),
    .rst  (RST),
    .en   (run_s),
    .clr  (start_s || clr_s),
    .tick (tick_s)
  );

  // Value the counter holds while idle: zero for up-count, the clamped preset for countdown.
  always_comb begin
    idle_val_s = '0;
    if (mode[0]) begin
      idle_val_s.m = clamp8(load_m, M_MAX);
      idle_val_s.s = clamp8(load_s, S_MAX);
    end else begin
      idle_val_s = '0;
    end
  end
  assign load_zero_s = mode[0] && (idle_val_s.m == 8'd0) && (idle_val_s.s == 8'd0);

  // Up-count with carries; wrap_s flags the roll-over from the top value.
  always_comb begin
    inc_s  = cnt_r;
    wrap_s = 1'b0;
    if (cnt_r.cs != CS_MAX) begin
      inc_s.cs = cnt_r.cs + 8'd1;
    end else begin
      inc_s.cs = 8'd0;
      if (cnt_r.s != S_MAX) begin
        inc_s.s = cnt_r.s + 8'd1;
      end else begin
        inc_s.s = 8'd0;
        if (cnt_r.m != M_MAX) begin
          inc_s.m = cnt_r.m + 8'd1;
        end else begin
          inc_s.m = 8'd0;
          wrap_s  = 1'b1;
        end
      end
    end
  end

  // Down-count with borrows.
  always_comb begin
    dec_s = cnt_r;
    if (cnt_r.cs != 8'd0) begin
      dec_s.cs = cnt_r.cs - 8'd1;
    end else begin
      dec_s.cs = CS_MAX;
      if (cnt_r.s != 8'd0) begin
        dec_s.s = cnt_r.s - 8'd1;
      end else begin
        dec_s.s = S_MAX;
        dec_s.m = cnt_r.m - 8'd1;
      end
    end
  end
  assign zero_s = (dec_s == '0);

  // Next state from the buttons, then clear and countdown-expiry override it.
  always_comb begin
    btn_nx_s   = state_r;
    state_nx_s = state_r;
    push_s     = 1'b0;
    start_s    = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_s && load_zero_s) begin
          btn_nx_s  = ST_DONE;
          done_nx_s = 1'b1;
        end else if (ss_s) begin
          btn_nx_s = ST_RUN;
          start_s  = 1'b1;
        end else begin
          btn_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ss_s) begin
          btn_nx_s = ST_PAUSE;
        end else if (lap_s) begin
          btn_nx_s = ST_SPLIT;
          push_s   = 1'b1;
        end else begin
          btn_nx_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ss_s) begin
          btn_nx_s = ST_RUN;
        end else begin
          btn_nx_s = ST_PAUSE;
        end
      end
      ST_SPLIT: begin
        if (ss_s) begin
          btn_nx_s = ST_RUN;
        end else if (lap_s) begin
          btn_nx_s = ST_SPLIT;
          push_s   = 1'b1;
        end else begin
          btn_nx_s = ST_SPLIT;
        end
      end
      ST_DONE: begin
        if (ss_s) begin
          btn_nx_s = ST_IDLE;
        end else begin
          btn_nx_s = ST_DONE;
        end
      end
      default: btn_nx_s = ST_IDLE;
    endcase
    if (clr_s) begin
      state_nx_s = ST_IDLE;
      push_s     = 1'b0;
      start_s    = 1'b0;
      done_nx_s  = 1'b0;
    end else if (tick_s && dir_r && zero_s) begin
      state_nx_s = ST_DONE;
      done_nx_s  = 1'b1;
    end else begin
      state_nx_s = btn_nx_s;
    end
  end

  // FSM state, done pulse and the direction latched while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= done_nx_s;
      if (state_r == ST_IDLE) begin
        dir_r <= mode[0];
      end
    end
  end

  // Time counter, overflow flag and frozen split value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= '0;
      frz_r <= '0;
      ovf_r <= 1'b0;
    end else if (clr_s) begin
      cnt_r <= idle_val_s;
      frz_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE) begin
        cnt_r <= idle_val_s;
      end else if (tick_s && dir_r) begin
        cnt_r <= dec_s;
      end else if (tick_s) begin
        cnt_r <= inc_s;
        if (wrap_s) begin
          ovf_r <= 1'b1;
        end
      end
      if (push_s) begin
        frz_r <= cnt_r;
      end
    end
  end

  // A pop frees the slot a same-cycle push needs when the FIFO is full.
  assign empty_s   = (wr_r == rd_r);
  assign full_s    = (wr_r[PTR_W] != rd_r[PTR_W]) && (wr_r[PTR_W-1:0] == rd_r[PTR_W-1:0]);
  assign do_pop_s  = lap_rd && !empty_s && !clr_s;
  assign do_push_s = push_s && (!full_s || do_pop_s);

  // FIFO pointers and the sticky dropped-lap flag.
  always_ff @(posedge CLK) begin
    if (RST || clr_s) begin
      wr_r   <= '0;
      rd_r   <= '0;
      lost_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_r <= wr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_r <= rd_r + PW'(1);
      end
      if (push_s && !do_push_s) begin
        lost_r <= 1'b1;
      end
    end
  end

  // FIFO storage; the captured value is the counter before this cycle's tick.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_r[PTR_W-1:0]] <= cnt_r;
    end
  end

  assign disp_m    = (state_r == ST_SPLIT) ? frz_r.m  : cnt_r.m;
  assign disp_s    = (state_r == ST_SPLIT) ? frz_r.s  : cnt_r.s;
  assign disp_cs   = (state_r == ST_SPLIT) ? frz_r.cs : cnt_r.cs;
  assign state     = state_r;
  assign done      = done_r;
  assign ovf       = ovf_r;
  assign lap_data  = empty_s ? '0 : mem_r[rd_r[PTR_W-1:0]];
  assign lap_empty = empty_s;
  assign lap_full  = full_s;
  assign lap_lost  = lost_r;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Self-checking bench: clamp table, directed corner sequences, and random stimulus vs a time-total model.
module tb_lap_stopwatch_core;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, btn_ss, btn_lap, btn_clr, lap_rd;
  logic [0:0] mode;
  logic [7:0] load_m, load_s;
  logic [7:0] disp_cs, disp_s, disp_m;
  logic [2:0] state;
  logic       done, ovf, lap_empty, lap_full, lap_lost;
  logic [23:0] lap_data;

  logic       f_rst, f_ss, f_clr;
  logic [7:0] f_cs, f_s, f_m;
  logic [2:0] f_state;
  logic       f_done, f_ovf, f_empty, f_full, f_lost;
  logic [23:0] f_data;

  int checks = 0;
  int errors = 0;

  lap_stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_MAX(2), .LAP_DEPTH(4), .MODE_W(1)) dut (
    .CLK(CLK), .RST(RST), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .mode(mode), .load_m(load_m), .load_s(load_s), .lap_rd(lap_rd),
    .disp_cs(disp_cs), .disp_s(disp_s), .disp_m(disp_m), .state(state), .done(done),
    .ovf(ovf), .lap_data(lap_data), .lap_empty(lap_empty), .lap_full(lap_full),
    .lap_lost(lap_lost)
  );

  // One tick per clock so the overflow roll-over is reachable in a short run.
  lap_stopwatch_core #(.CLK_HZ(100), .TICK_HZ(100), .MIN_MAX(1), .LAP_DEPTH(2), .MODE_W(1)) dut_fast (
    .CLK(CLK), .RST(f_rst), .btn_ss(f_ss), .btn_lap(1'b0), .btn_clr(f_clr),
    .mode(1'b0), .load_m(8'd0), .load_s(8'd0), .lap_rd(1'b0),
    .disp_cs(f_cs), .disp_s(f_s), .disp_m(f_m), .state(f_state), .done(f_done),
    .ovf(f_ovf), .lap_data(f_data), .lap_empty(f_empty), .lap_full(f_full),
    .lap_lost(f_lost)
  );

  logic [55:0] act_v;
  assign act_v = {disp_m, disp_s, disp_cs, state, done, ovf, lap_data, lap_empty, lap_full, lap_lost};

  localparam logic [55:0] RESET_V = {24'd0, 3'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0};

  typedef struct {
    logic       md;
    logic [7:0] lm;
    logic [7:0] ls;
    logic [7:0] em;
    logic [7:0] es;
  } vec_t;
  vec_t tbl [6];

  // Reference model: time kept as total centiseconds, laps in a queue.
  int   ms, mphase, mtot, mfrz;
  logic mdir, movf, mdone, mlost;
  logic [23:0] mq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_ss();  btn_ss  = 1'b1; step(1); btn_ss  = 1'b0; endtask
  task automatic pulse_lap(); btn_lap = 1'b1; step(1); btn_lap = 1'b0; endtask
  task automatic pulse_clr(); btn_clr = 1'b1; step(1); btn_clr = 1'b0; endtask
  task automatic pulse_rd();  lap_rd  = 1'b1; step(1); lap_rd  = 1'b0; endtask

  function automatic logic [23:0] tot2lap(input int t);
    logic [7:0] m, s, c;
    m = 8'(t / 6000);
    s = 8'((t / 100) % 60);
    c = 8'(t % 100);
    return {m, s, c};
  endfunction

  function automatic logic [55:0] model_vec();
    logic [23:0] d, h;
    d = tot2lap((ms == 3) ? mfrz : mtot);
    h = (mq.size() > 0) ? mq[0] : 24'd0;
    return {d, 3'(ms), mdone, movf, h, mq.size() == 0, mq.size() == 4, mlost};
  endfunction

  task automatic model_reset();
    ms = 0; mphase = 0; mtot = 0; mfrz = 0;
    mdir = 1'b0; movf = 1'b0; mdone = 1'b0; mlost = 1'b0;
    mq.delete();
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int ld, ns, ntot, o_state;
    logic clr, ss, lap, run, tick, push, start, o_dir;
    logic [23:0] cap;
    ld = ((load_m > 8'd2) ? 2 : int'(load_m)) * 6000 + ((load_s > 8'd59) ? 59 : int'(load_s)) * 100;
    clr = btn_clr;
    ss  = btn_ss && !btn_clr;
    lap = btn_lap && !btn_ss && !btn_clr;
    run = (ms == 1) || (ms == 3);
    tick = run && (mphase == 9);
    cap = tot2lap(mtot);
    o_state = ms;
    o_dir = mdir;
    mdone = 1'b0;
    if (clr) begin
      ms = 0; mphase = 0; mfrz = 0; movf = 1'b0; mlost = 1'b0;
      mq.delete();
      mtot = mode[0] ? ld : 0;
    end else begin
      ns = ms; push = 1'b0; start = 1'b0;
      case (ms)
        0: if (ss) begin
             if (mode[0] && ld == 0) begin ns = 4; mdone = 1'b1; end
             else begin ns = 1; start = 1'b1; end
           end
        1: if (ss) ns = 2; else if (lap) begin ns = 3; push = 1'b1; end
        2: if (ss) ns = 1;
        3: if (ss) ns = 1; else if (lap) push = 1'b1;
        4: if (ss) ns = 0;
        default: ns = 0;
      endcase
      ntot = mtot;
      if (tick) begin
        if (o_dir) begin
          ntot = mtot - 1;
          if (ntot == 0) begin ns = 4; mdone = 1'b1; end
        end else begin
          ntot = mtot + 1;
          if (ntot == 18000) begin ntot = 0; movf = 1'b1; end
        end
      end
      if (ms == 0) ntot = mode[0] ? ld : 0;
      if (start) mphase = 0;
      else if (run) mphase = tick ? 0 : mphase + 1;
      if (lap_rd && mq.size() > 0) void'(mq.pop_front());
      if (push) begin
        mfrz = mtot;
        if (mq.size() < 4) mq.push_back(cap);
        else mlost = 1'b1;
      end
      mtot = ntot;
      ms = ns;
    end
    if (o_state == 0) mdir = mode[0];
  endtask

  int lsv [5] = '{0, 1, 2, 3, 70};

  initial begin
    tbl[0] = '{1'b1, 8'd1,   8'd30,  8'd1, 8'd30};
    tbl[1] = '{1'b1, 8'd5,   8'd30,  8'd2, 8'd30};
    tbl[2] = '{1'b1, 8'd2,   8'd60,  8'd2, 8'd59};
    tbl[3] = '{1'b1, 8'd255, 8'd255, 8'd2, 8'd59};
    tbl[4] = '{1'b0, 8'd1,   8'd30,  8'd0, 8'd0};
    tbl[5] = '{1'b1, 8'd0,   8'd7,   8'd0, 8'd7};

    RST = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0; lap_rd = 1'b0;
    mode = 1'b0; load_m = 8'd0; load_s = 8'd0;
    f_rst = 1'b1; f_ss = 1'b0; f_clr = 1'b0;
    step(2);
    chk("reset_outputs", 64'(act_v), 64'(RESET_V));
    RST = 1'b0;

    // Idle countdown preset tracking with clamping.
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].md; load_m = tbl[i].lm; load_s = tbl[i].ls;
      step(1);
      chk("idle_preset", 64'({disp_m, disp_s, disp_cs, state}),
          64'({tbl[i].em, tbl[i].es, 8'd0, 3'd0}));
    end

    // Run 6000 cycles, pause, hold.
    mode = 1'b0; step(1);
    pulse_ss();
    chk("run_state", 64'(state), 64'(3'd1));
    step(6000);
    chk("run_6s", 64'({disp_m, disp_s, disp_cs, state}), 64'({8'd0, 8'd6, 8'd0, 3'd1}));
    pulse_ss();
    chk("pause_state", 64'(state), 64'(3'd2));
    step(100);
    chk("pause_hold", 64'({disp_m, disp_s, disp_cs}), 64'({8'd0, 8'd6, 8'd0}));

    // Split freezes the display while the count continues.
    pulse_clr();
    chk("clr_idle", 64'({state, disp_m, disp_s, disp_cs}), 64'({3'd0, 24'd0}));
    pulse_ss();
    step(505);
    pulse_lap();
    chk("split_frozen", 64'({state, disp_m, disp_s, disp_cs, lap_data}),
        64'({3'd3, 8'd0, 8'd0, 8'd50, 24'h000032}));
    step(100);
    chk("split_hold", 64'({disp_m, disp_s, disp_cs}), 64'({8'd0, 8'd0, 8'd50}));
    pulse_ss();
    chk("split_live", 64'({state, disp_m, disp_s, disp_cs, lap_data}),
        64'({3'd1, 8'd0, 8'd0, 8'd60, 24'h000032}));

    // Overfill the FIFO, then push and pop together while full.
    pulse_clr();
    pulse_ss();
    for (int i = 0; i < 5; i++) begin
      step(20);
      pulse_lap();
    end
    chk("fifo_full_lost", 64'({lap_full, lap_lost, lap_empty, lap_data}), 64'({3'b110, 24'd2}));
    btn_lap = 1'b1; lap_rd = 1'b1;
    step(1);
    btn_lap = 1'b0; lap_rd = 1'b0;
    chk("fifo_pushpop", 64'({lap_full, lap_data}), 64'({1'b1, 24'd4}));
    pulse_rd();
    chk("fifo_pop1", 64'({lap_full, lap_data}), 64'({1'b0, 24'd6}));
    pulse_rd();
    chk("fifo_pop2", 64'(lap_data), 64'(24'd8));
    pulse_rd();
    chk("fifo_newest", 64'({lap_empty, lap_data}), 64'({1'b0, 24'd10}));
    pulse_rd();
    chk("fifo_drained", 64'({lap_empty, lap_data}), 64'({1'b1, 24'd0}));
    pulse_rd();
    chk("fifo_pop_empty", 64'({lap_empty, lap_full, lap_data}), 64'({2'b10, 24'd0}));

    // Countdown from 0:01.00 to zero.
    pulse_clr();
    mode = 1'b1; load_m = 8'd0; load_s = 8'd1;
    step(1);
    chk("down_preset", 64'({disp_m, disp_s, disp_cs}), 64'({8'd0, 8'd1, 8'd0}));
    pulse_ss();
    step(999);
    chk("down_last", 64'({state, done, disp_m, disp_s, disp_cs}), 64'({3'd1, 1'b0, 24'd1}));
    step(1);
    chk("down_done", 64'({state, done, disp_m, disp_s, disp_cs}), 64'({3'd4, 1'b1, 24'd0}));
    step(1);
    chk("done_one_cycle", 64'({state, done}), 64'({3'd4, 1'b0}));
    pulse_ss();
    chk("done_to_idle", 64'(state), 64'(3'd0));

    // Countdown preset of zero goes straight to DONE.
    load_s = 8'd0;
    step(1);
    pulse_ss();
    chk("zero_load_done", 64'({state, done}), 64'({3'd4, 1'b1}));
    pulse_ss();

    // All three buttons together: clear wins.
    mode = 1'b0; step(1);
    pulse_ss();
    pulse_lap();
    step(30);
    btn_ss = 1'b1; btn_lap = 1'b1; btn_clr = 1'b1;
    step(1);
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    chk("all_buttons", 64'({state, disp_m, disp_s, disp_cs, lap_empty, lap_lost}),
        64'({3'd0, 24'd0, 1'b1, 1'b0}));

    // Reset in the middle of a split.
    pulse_ss();
    step(55);
    pulse_lap();
    step(5);
    RST = 1'b1;
    step(1);
    chk("mid_run_reset", 64'(act_v), 64'(RESET_V));
    RST = 1'b0;

    // Up-count overflow on the one-tick-per-clock instance.
    f_rst = 1'b0;
    step(1);
    f_ss = 1'b1; step(1); f_ss = 1'b0;
    step(11999);
    chk("ovf_top", 64'({f_m, f_s, f_cs, f_ovf}), 64'({8'd1, 8'd59, 8'd99, 1'b0}));
    step(1);
    chk("ovf_wrap", 64'({f_m, f_s, f_cs, f_ovf, f_state}), 64'({24'd0, 1'b1, 3'd1}));
    step(1);
    chk("ovf_sticky", 64'({f_cs, f_ovf}), 64'({8'd1, 1'b1}));
    f_clr = 1'b1; step(1); f_clr = 1'b0;
    chk("ovf_clr", 64'({f_state, f_done, f_ovf, f_data, f_empty, f_full, f_lost, f_cs}),
        64'({3'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 8'd0}));

    // Random stimulus against the model.
    RST = 1'b1; step(1); RST = 1'b0;
    model_reset();
    for (int i = 0; i < 5000; i++) begin
      btn_ss  = ($urandom_range(0, 99) < 3);
      btn_lap = ($urandom_range(0, 99) < 4);
      btn_clr = ($urandom_range(0, 999) < 4);
      lap_rd  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 2) begin
        mode   = 1'($urandom_range(0, 1));
        load_m = ($urandom_range(0, 9) == 0) ? 8'd7 : 8'd0;
        load_s = 8'(lsv[$urandom_range(0, 4)]);
      end
      model_step();
      @(posedge CLK);
      #1;
      chk("random", 64'(act_v), 64'(model_vec()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
